// File: rtl/nclic_arbiter_if.sv
// Purpose: claim/complete bus between the CLIC arbiter, the per-line config registers and the core.
// Latency: none. This is wiring only; all timing is set by nclic_arbiter.
// Backpressure: the offer uses claim_valid/claim_ready; completion is a one-cycle pulse and cannot be stalled.
interface nclic_arbiter_if #(
  parameter int NumIrq    = 16,
  parameter int PrioWidth = 4
);
  localparam int IdWidth = $clog2(NumIrq);

  logic [NumIrq-1:0]    irq_pending;
  logic [NumIrq-1:0]    irq_enable;
  logic [PrioWidth-1:0] irq_prio [NumIrq];
  logic [PrioWidth-1:0] threshold;
  logic                 claim_valid;
  logic [IdWidth-1:0]   claim_id;
  logic [PrioWidth-1:0] claim_prio;
  logic                 claim_ready;
  logic                 complete;
  logic [IdWidth-1:0]   complete_id;
  logic                 active;
  logic [IdWidth-1:0]   active_id;
  logic                 err_complete;

  // Arbiter side.
  modport master (
    input  irq_pending, irq_enable, irq_prio, threshold, claim_ready, complete, complete_id,
    output claim_valid, claim_id, claim_prio, active, active_id, err_complete
  );

  // Core and config-register side.
  modport slave (
    output irq_pending, irq_enable, irq_prio, threshold, claim_ready, complete, complete_id,
    input  claim_valid, claim_id, claim_prio, active, active_id, err_complete
  );
endinterface

// File: rtl/nclic_arbiter.sv
// Purpose: per-hart CLIC scheduler that masks lines, picks the highest priority through a max tree, and tracks claim/complete.
// Latency: the offer is registered and appears 1 cycle after the inputs change. A claim or completion updates active on the next edge.
// Backpressure: the offer is held and re-evaluated every cycle until claim_ready. Build option NCLIC_NESTING_EN enables a preemption stack.
module nclic_arbiter #(
  parameter int NumIrq    = 16,
  parameter int PrioWidth = 4,
  parameter int NestDepth = 4
) (
  input logic            clk,
  input logic            rst_n,
  nclic_arbiter_if.master bus
);
  localparam int IdW    = $clog2(NumIrq);
  localparam int Leaves = 1 << IdW;

  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, ACTIVE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [IdW-1:0]       offer_id_q, offer_id_d;
  logic [PrioWidth-1:0] offer_prio_q, offer_prio_d;
  logic                 err_q, err_d;
  logic                 claim_vld, hs, cmp_ok, busy_d, room_d, offer_vld;
  logic [IdW-1:0]       top_id;
  logic [PrioWidth-1:0] level;
  logic [NumIrq-1:0]    in_svc, elig;
  // Max-priority tree; node n has children 2n and 2n+1, and the leaves start at Leaves.
  logic                 nd_vld  [1:2*Leaves-1];
  logic [IdW-1:0]       nd_id   [1:2*Leaves-1];
  logic [PrioWidth-1:0] nd_prio [1:2*Leaves-1];

`ifdef NCLIC_NESTING_EN
  localparam int DepW = $clog2(NestDepth + 1);
  // Shift-register stack. Entry 0 is always the irq currently in service.
  logic [IdW-1:0]       stk_id_q   [NestDepth];
  logic [IdW-1:0]       stk_id_d   [NestDepth];
  logic [PrioWidth-1:0] stk_prio_q [NestDepth];
  logic [PrioWidth-1:0] stk_prio_d [NestDepth];
  logic [DepW-1:0]      depth_q, depth_d;
  logic                 pre_vld_q, pre_vld_d;

  assign top_id    = stk_id_q[0];
  assign claim_vld = (state_q == OFFER) || pre_vld_q;
`else
  logic [IdW-1:0]       act_id_q, act_id_d;
  logic [PrioWidth-1:0] act_prio_q, act_prio_d;

  assign top_id    = act_id_q;
  assign claim_vld = (state_q == OFFER);
`endif

  // Next-state logic: retire the completion first, then accept the claim, then offer the best line from the stack that results.
  always_comb begin
    hs     = claim_vld && bus.claim_ready;
    cmp_ok = bus.complete && (state_q == ACTIVE) && (bus.complete_id == top_id);
    err_d  = err_q || (bus.complete && !cmp_ok);
    in_svc = '0;
    level  = bus.threshold;
`ifdef NCLIC_NESTING_EN
    stk_id_d   = stk_id_q;
    stk_prio_d = stk_prio_q;
    depth_d    = depth_q;
    if (cmp_ok) begin
      for (int j = 0; j < NestDepth - 1; j++) begin
        stk_id_d[j]   = stk_id_d[j+1];
        stk_prio_d[j] = stk_prio_d[j+1];
      end
      depth_d = depth_d - 1'b1;
    end
    if (hs) begin
      for (int j = NestDepth - 1; j > 0; j--) begin
        stk_id_d[j]   = stk_id_d[j-1];
        stk_prio_d[j] = stk_prio_d[j-1];
      end
      stk_id_d[0]   = offer_id_q;
      stk_prio_d[0] = offer_prio_q;
      depth_d       = depth_d + 1'b1;
    end
    busy_d = (depth_d != '0);
    room_d = (depth_d < DepW'(NestDepth));
    for (int i = 0; i < NumIrq; i++) begin
      for (int j = 0; j < NestDepth; j++) begin
        if ((DepW'(j) < depth_d) && (stk_id_d[j] == IdW'(i))) begin
          in_svc[i] = 1'b1;
        end
      end
    end
    if (busy_d && (stk_prio_d[0] > level)) level = stk_prio_d[0];
`else
    act_id_d   = act_id_q;
    act_prio_d = act_prio_q;
    busy_d     = (state_q == ACTIVE);
    if (cmp_ok) busy_d = 1'b0;
    if (hs) begin
      busy_d     = 1'b1;
      act_id_d   = offer_id_q;
      act_prio_d = offer_prio_q;
    end
    room_d = !busy_d;
    for (int i = 0; i < NumIrq; i++) begin
      in_svc[i] = busy_d && (act_id_d == IdW'(i));
    end
    if (busy_d && (act_prio_d > level)) level = act_prio_d;
`endif
    for (int i = 0; i < NumIrq; i++) begin
      elig[i] = bus.irq_pending[i] && bus.irq_enable[i] && (bus.irq_prio[i] > level) && !in_svc[i];
    end
    for (int n = 1; n < 2 * Leaves; n++) begin
      nd_vld[n]  = 1'b0;
      nd_id[n]   = '0;
      nd_prio[n] = '0;
    end
    for (int i = 0; i < NumIrq; i++) begin
      nd_vld[Leaves+i]  = elig[i];
      nd_id[Leaves+i]   = IdW'(i);
      nd_prio[Leaves+i] = bus.irq_prio[i];
    end
    // The right child wins only on strictly higher priority, so ties go to the lower index.
    for (int n = Leaves - 1; n >= 1; n--) begin
      if (nd_vld[2*n+1] && (!nd_vld[2*n] || (nd_prio[2*n+1] > nd_prio[2*n]))) begin
        nd_vld[n]  = 1'b1;
        nd_id[n]   = nd_id[2*n+1];
        nd_prio[n] = nd_prio[2*n+1];
      end else begin
        nd_vld[n]  = nd_vld[2*n];
        nd_id[n]   = nd_id[2*n];
        nd_prio[n] = nd_prio[2*n];
      end
    end
    offer_vld    = nd_vld[1] && room_d;
    offer_id_d   = offer_vld ? nd_id[1] : '0;
    offer_prio_d = offer_vld ? nd_prio[1] : '0;
    state_d      = busy_d ? ACTIVE : (nd_vld[1] ? OFFER : IDLE);
`ifdef NCLIC_NESTING_EN
    pre_vld_d    = busy_d && offer_vld;
`endif
  end

  // State register, registered offer and sticky completion error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      offer_id_q   <= '0;
      offer_prio_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      offer_id_q   <= offer_id_d;
      offer_prio_q <= offer_prio_d;
      err_q        <= err_d;
    end
  end

`ifdef NCLIC_NESTING_EN
  // Preemption stack and the offer-while-active flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NestDepth; j++) begin
        stk_id_q[j]   <= '0;
        stk_prio_q[j] <= '0;
      end
      depth_q   <= '0;
      pre_vld_q <= 1'b0;
    end else begin
      stk_id_q   <= stk_id_d;
      stk_prio_q <= stk_prio_d;
      depth_q    <= depth_d;
      pre_vld_q  <= pre_vld_d;
    end
  end
`else
  // Single active slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_id_q   <= '0;
      act_prio_q <= '0;
    end else begin
      act_id_q   <= act_id_d;
      act_prio_q <= act_prio_d;
    end
  end
`endif

  assign bus.claim_valid  = claim_vld;
  assign bus.claim_id     = offer_id_q;
  assign bus.claim_prio   = offer_prio_q;
  assign bus.active       = (state_q == ACTIVE);
  assign bus.active_id    = (state_q == ACTIVE) ? top_id : '0;
  assign bus.err_complete = err_q;
endmodule

// File: tb/tb_nclic_arbiter.sv
// Purpose: bench for nclic_arbiter. It runs directed scenarios, then random traffic checked against a queue-based model.
// Latency: the model is advanced once per clock edge, and outputs are sampled 1 time unit after that edge.
// Backpressure: claim_ready and complete are driven randomly, including cycles with no offer and completions with a bad id.
module tb_nclic_arbiter;
  localparam int N  = 16;
  localparam int PW = 4;
  localparam int ND = 4;
`ifdef NCLIC_NESTING_EN
  localparam int Cap = ND;
`else
  localparam int Cap = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nclic_arbiter_if #(.NumIrq(N), .PrioWidth(PW)) bus();
  nclic_arbiter #(.NumIrq(N), .PrioWidth(PW), .NestDepth(ND)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the in-service stack as queues (top at the back) plus the registered offer.
  int m_id[$];
  int m_pr[$];
  bit m_vld;
  int m_oid;
  int m_opr;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_stack(input int id);
    foreach (m_id[k]) if (m_id[k] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit hs, ok, found;
    int lvl, best, bp;
    if (!rst_n) begin
      m_id.delete();
      m_pr.delete();
      m_vld = 0; m_oid = 0; m_opr = 0; m_err = 0;
    end else begin
      hs = m_vld && (bus.claim_ready == 1'b1);
      ok = (bus.complete == 1'b1) && (m_id.size() > 0) && (int'(bus.complete_id) == m_id[$]);
      if (bus.complete == 1'b1 && !ok) m_err = 1;
      if (ok) begin
        void'(m_id.pop_back());
        void'(m_pr.pop_back());
      end
      if (hs) begin
        m_id.push_back(m_oid);
        m_pr.push_back(m_opr);
      end
      lvl = int'(bus.threshold);
      if (m_id.size() > 0 && m_pr[$] > lvl) lvl = m_pr[$];
      found = 0; best = 0; bp = 0;
      for (int i = 0; i < N; i++) begin
        if (bus.irq_pending[i] && bus.irq_enable[i] && int'(bus.irq_prio[i]) > lvl && !in_stack(i)
            && (!found || int'(bus.irq_prio[i]) > bp)) begin
          found = 1; best = i; bp = int'(bus.irq_prio[i]);
        end
      end
      m_vld = found && (m_id.size() < Cap);
      m_oid = m_vld ? best : 0;
      m_opr = m_vld ? bp : 0;
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("claim_valid", bus.claim_valid, m_vld);
    chk("claim_id", bus.claim_id, m_oid);
    chk("claim_prio", bus.claim_prio, m_opr);
    chk("active", bus.active, (m_id.size() > 0));
    chk("active_id", bus.active_id, (m_id.size() > 0) ? m_id[$] : 0);
    chk("err_complete", bus.err_complete, m_err);
  endtask

  task automatic clear_lines();
    bus.irq_pending = '0;
    bus.irq_enable  = '1;
    for (int i = 0; i < N; i++) bus.irq_prio[i] = '0;
  endtask

  task automatic set_line(input int id, input int p);
    bus.irq_pending[id] = 1'b1;
    bus.irq_enable[id]  = 1'b1;
    bus.irq_prio[id]    = PW'(p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic claim();
    bus.claim_ready = 1'b1;
    tick();
    bus.claim_ready = 1'b0;
  endtask

  task automatic comp(input int id);
    bus.complete    = 1'b1;
    bus.complete_id = 4'(id);
    tick();
    bus.complete    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.irq_pending = '1;
    bus.irq_enable  = '1;
    for (int i = 0; i < N; i++) bus.irq_prio[i] = 4'd1;
    bus.threshold   = '0;
    bus.claim_ready = 1'b0;
    bus.complete    = 1'b0;
    bus.complete_id = '0;

    // Reset with every line pending.
    tick(); tick();
    chk("rst_valid", bus.claim_valid, 0);
    chk("rst_id", bus.claim_id, 0);
    chk("rst_active", bus.active, 0);
    chk("rst_err", bus.err_complete, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_valid", bus.claim_valid, 1);
    chk("rel_id", bus.claim_id, 0);

    // Highest priority wins; a pending drop does not end service.
    clear_lines(); set_line(3, 5); set_line(7, 9); bus.threshold = 4'd2;
    do_reset(); tick();
    chk("pick_id", bus.claim_id, 7);
    chk("pick_prio", bus.claim_prio, 9);
    claim();
    chk("claim_active_id", bus.active_id, 7);
    chk("claim_valid_off", bus.claim_valid, 0);
    bus.irq_pending[7] = 1'b0;
    tick();
    chk("drop_still_active", bus.active, 1);
    comp(7);
    chk("after_cmp_active", bus.active, 0);
    chk("after_cmp_id", bus.claim_id, 3);

    // A tie goes to the lower index; the threshold is strict.
    clear_lines(); set_line(2, 6); set_line(5, 6); bus.threshold = 4'd0;
    do_reset(); tick();
    chk("tie_id", bus.claim_id, 2);
    bus.threshold = 4'd6;
    tick();
    chk("thr_masks", bus.claim_valid, 0);

    // A completion while idle sets a sticky error, which reset clears.
    clear_lines(); bus.threshold = 4'd0;
    do_reset(); comp(4);
    chk("idle_cmp_err", bus.err_complete, 1);
    chk("idle_cmp_active", bus.active, 0);
    tick(); tick(); tick();
    chk("err_sticky", bus.err_complete, 1);
    do_reset(); tick();
    chk("err_cleared", bus.err_complete, 0);

    // Completion and claim_ready in the same cycle.
    clear_lines(); set_line(7, 9);
    do_reset(); tick(); claim();
    bus.irq_pending[7] = 1'b0; set_line(3, 5);
    tick();
    bus.claim_ready = 1'b1;
    comp(7);
    bus.claim_ready = 1'b0;
    claim();
    chk("simul_active_id", bus.active_id, 3);

`ifdef NCLIC_NESTING_EN
    // Preemption: a higher-priority line nests, and only the top of the stack may complete.
    clear_lines(); set_line(3, 5);
    do_reset(); tick(); claim();
    set_line(9, 12);
    tick();
    chk("nest_offer", bus.claim_id, 9);
    claim();
    chk("nest_active", bus.active_id, 9);
    bus.irq_pending[9] = 1'b0;
    comp(3);
    chk("nest_bad_err", bus.err_complete, 1);
    chk("nest_bad_keep", bus.active_id, 9);
    comp(9);
    chk("nest_restore", bus.active_id, 3);
`endif

    // Random traffic against the model.
    clear_lines();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0)  bus.irq_pending = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.irq_enable  = 16'($urandom);
      if ($urandom_range(0, 3) == 0)  bus.irq_prio[$urandom_range(0, N - 1)] = PW'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) bus.threshold = PW'($urandom_range(0, 6));
      bus.claim_ready = ($urandom_range(0, 1) == 1);
      bus.complete    = ($urandom_range(0, 3) == 0);
      bus.complete_id = (m_id.size() > 0 && $urandom_range(0, 9) != 0) ? 4'(m_id[$]) : 4'($urandom_range(0, N - 1));
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
